// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode constants, IR field positions, sequencer state
// encoding and opcode classification helpers for the processor control path.
package proc_pkg;

  localparam int OPC_WIDTH = 5;

  // Opcode field position inside the 32-bit instruction register.
  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;

  typedef logic [OPC_WIDTH-1:0] opcode_t;

  // ALU group occupies 00000..01011; 00000 writes a GPR but leaves flags alone.
  localparam opcode_t OPC_ALU_LAST  = 5'b01011;
  localparam opcode_t OPC_RSVD_0    = 5'b01100;
  localparam opcode_t OPC_STOREREG  = 5'b01101;
  localparam opcode_t OPC_STOREDIN  = 5'b01110;
  localparam opcode_t OPC_SENDDOUT  = 5'b01111;
  localparam opcode_t OPC_RSVD_1    = 5'b10000;
  localparam opcode_t OPC_SENDREG   = 5'b10001;
  localparam opcode_t OPC_JUMP      = 5'b10010;
  localparam opcode_t OPC_JCARRY    = 5'b10011;
  localparam opcode_t OPC_JNOCARRY  = 5'b10100;
  localparam opcode_t OPC_JSIGN     = 5'b10101;
  localparam opcode_t OPC_JNOSIGN   = 5'b10110;
  localparam opcode_t OPC_JZERO     = 5'b10111;
  localparam opcode_t OPC_JNOZERO   = 5'b11000;
  localparam opcode_t OPC_JOVF      = 5'b11001;
  localparam opcode_t OPC_JNOOVF    = 5'b11010;
  localparam opcode_t OPC_HALT      = 5'b11011;
  localparam opcode_t OPC_RSVD_HI   = 5'b11100;  // 11100..11111 undefined

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OPC_STOREREG) || (op == OPC_STOREDIN) ||
           (op == OPC_SENDDOUT) || (op == OPC_SENDREG);
  endfunction

  function automatic logic is_wb_op(input opcode_t op);
    return (op <= OPC_ALU_LAST) || (op == OPC_SENDREG);
  endfunction

  function automatic logic is_flag_op(input opcode_t op);
    return (op != 5'b00000) && (op <= OPC_ALU_LAST);
  endfunction

  function automatic logic is_illegal(input opcode_t op);
    return (op == OPC_RSVD_0) || (op == OPC_RSVD_1) || (op >= OPC_RSVD_HI);
  endfunction

  function automatic logic is_jump_op(input opcode_t op);
    return (op >= OPC_JUMP) && (op <= OPC_JNOOVF);
  endfunction

endpackage

// File: rtl/proc_branch_eval.sv
// proc_branch_eval: decides whether a jump opcode is taken given the
// current condition flags. Non-jump opcodes are never taken.
module proc_branch_eval
  import proc_pkg::*;
(
  input  logic [OPC_WIDTH-1:0] oper_type_i,
  input  logic                 flag_sign_i,
  input  logic                 flag_zero_i,
  input  logic                 flag_carry_i,
  input  logic                 flag_ovf_i,
  output logic                 taken_o
);

  // Pure lookup of the condition selected by the jump opcode.
  always_comb begin
    taken_o = 1'b0;
    case (oper_type_i)
      OPC_JUMP:     taken_o = 1'b1;
      OPC_JCARRY:   taken_o = flag_carry_i;
      OPC_JNOCARRY: taken_o = ~flag_carry_i;
      OPC_JSIGN:    taken_o = flag_sign_i;
      OPC_JNOSIGN:  taken_o = ~flag_sign_i;
      OPC_JZERO:    taken_o = flag_zero_i;
      OPC_JNOZERO:  taken_o = ~flag_zero_i;
      OPC_JOVF:     taken_o = flag_ovf_i;
      OPC_JNOOVF:   taken_o = ~flag_ovf_i;
      default:      taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: multi-cycle control FSM for the single-issue datapath.
// Owns the PC, fetches over a req/ack handshake and issues one-cycle
// enable strobes per stage. Optional single-step support is compiled in
// with the SEQ_SINGLE_STEP_EN macro (adds step_mode/step ports).
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int OPC_W = 5
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic [OPC_W-1:0] oper_type,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic             flag_sign,
  input  logic             flag_zero,
  input  logic             flag_carry,
  input  logic             flag_ovf,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             flag_en,
  output logic             halted,
  output logic             illegal_op
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            taken;
  logic            go;
  logic            wb_to_idle;

  proc_branch_eval u_branch (
    .oper_type_i  (oper_type),
    .flag_sign_i  (flag_sign),
    .flag_zero_i  (flag_zero),
    .flag_carry_i (flag_carry),
    .flag_ovf_i   (flag_ovf),
    .taken_o      (taken)
  );

`ifdef SEQ_SINGLE_STEP_EN
  // In step mode only a step pulse launches a fetch and each instruction parks in IDLE.
  assign go         = step_mode ? step : start;
  assign wb_to_idle = step_mode;
`else
  assign go         = start;
  assign wb_to_idle = 1'b0;
`endif

  // Next-state, PC and branch-resolution logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    taken_d  = taken_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Undefined opcodes fall through to EXECUTE and behave as a NOP.
        state_d = (oper_type == OPC_HALT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        // Flags are sampled here, after the previous instruction's update landed.
        taken_d  = taken;
        target_d = jmp_target;
        state_d  = is_mem_op(oper_type) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_d    = taken_q ? target_q : pc_q + PC_W'(1);
        taken_d = 1'b0;
        state_d = wb_to_idle ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: begin
        if (go) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC and latched branch decision registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  // Strobes decode straight from state so reset clears them immediately.
  always_comb begin
    imem_req   = (state_q == ST_FETCH);
    ir_load    = (state_q == ST_FETCH) && imem_ack;
    illegal_op = (state_q == ST_DECODE) && is_illegal(oper_type);
    exec_en    = (state_q == ST_EXECUTE) && !is_jump_op(oper_type);
    mem_en     = (state_q == ST_MEMORY);
    wb_en      = (state_q == ST_WRITEBACK) && is_wb_op(oper_type);
    flag_en    = (state_q == ST_WRITEBACK) && is_flag_op(oper_type);
    halted     = (state_q == ST_HALT);
  end

  assign pc = pc_q;

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Multi-cycle control FSM that sequences the single-issue processor datapath. It owns the PC, fetches from instruction memory over a req/ack handshake, and steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK. It issues one-cycle enable strobes to the datapath and resolves conditional jumps from the condition flags. It also handles halt and illegal opcodes.

Parameters:
PC_W, 4, PC width; instruction space is 2^PC_W words; PC wraps modulo 2^PC_W.
OPC_W, 5, opcode field width (IR[31:27]).

Ports:
clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE, or resumes from HALT
pc  out  PC_W  current instruction address
imem_req  out  1  fetch request; held until imem_ack
imem_ack  in  1  instruction word valid this cycle
ir_load  out  1  1-cycle strobe: datapath latches IR
oper_type  in  OPC_W  opcode of latched IR
jmp_target  in  PC_W  IR[PC_W-1:0] (isrc low bits)
flag_sign, flag_zero, flag_carry, flag_ovf  in  1 each  registered condition flags from datapath
exec_en  out  1  1-cycle strobe: ALU/compute
mem_en  out  1  1-cycle strobe: data-memory access
wb_en  out  1  1-cycle strobe: GPR write
flag_en  out  1  1-cycle strobe: flag register update
halted  out  1  high while in HALT
illegal_op  out  1  1-cycle strobe in DECODE on undefined opcode

Behaviour:
- Reset (async, sys_rst_n=0) puts the block in IDLE with pc=0 and all strobes, imem_req, halted and illegal_op at 0. Reset mid-instruction aborts it with no strobe.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT (3-bit encoding).
- IDLE: start=1 moves to FETCH next cycle.
- FETCH: imem_req=1. On imem_ack=1, pulse ir_load in the same cycle and move to DECODE. With no ack, stay in FETCH indefinitely.
- DECODE, by oper_type:
  - halt (11011): move to HALT.
  - undefined (01100, 10000, 11100-11111): pulse illegal_op and treat as NOP.
  - everything else: move to EXECUTE.
- EXECUTE: exec_en=1 for ALU, load/store and NOP. Branches are resolved here from the flags sampled this cycle.
  - Load/store (01101 storereg, 01110 storedin, 01111 senddout, 10001 sendreg) go to MEMORY.
  - All others go to WRITEBACK.
- MEMORY: mem_en=1, then WRITEBACK.
- WRITEBACK:
  - wb_en=1 for opcodes 00000-01011 and 10001.
  - flag_en=1 for opcodes 00001-01011 only.
  - Update pc: target if the branch was taken, else pc+1 (pc=2^PC_W-1 wraps to 0). Then go to FETCH.
- Jump opcodes:
  - 10010 jump (unconditional)
  - 10011 jcarry / 10100 jnocarry
  - 10101 jsign / 10110 jnosign
  - 10111 jzero / 11000 jnozero
  - 11001 jovf / 11010 jnoovf
- Jumps never assert wb_en or flag_en. Flags updated by instruction N are visible to a branch at N+1.
- HALT: halted=1, pc unchanged. start=1 sets pc to pc+1 (wrapping) and moves to FETCH.
- Latency with imem_ack on the first FETCH cycle:
  - ALU, jump or NOP: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle on imem_ack adds one.
- At most one of exec_en, mem_en, ir_load is high in any cycle. wb_en and flag_en occur only in WRITEBACK.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined: adds two ports, step_mode (in, 1) and step (in, 1, pulse).
  - With step_mode=1, WRITEBACK moves to IDLE instead of FETCH; pc is already updated.
  - A step pulse in IDLE then fetches exactly one instruction. start is ignored while step_mode=1.
  - step_mode=0 gives normal behaviour.
- Undefined: the ports are absent and WRITEBACK always moves to FETCH.

Decomposition:
- Shared package proc_pkg holds the opcode constants (existing ALU/load/store codes plus the new jump and halt codes), the state enum typedef, the IR field positions, and the helper functions is_mem_op, is_wb_op, is_flag_op and is_illegal.
- One natural sub-module, proc_branch_eval: combinational function of oper_type and the four flags, producing taken. It is reused by the verification model.

Test Plan:
- Reset, start=1, program "add" with ack at once: ir_load at cycle 1, exec_en at 3, wb_en and flag_en at 4, pc 0->1.
- Fetch wait: hold imem_ack=0 for 3 cycles -> imem_req stays high, ir_load fires on the 4th FETCH cycle, no other strobe earlier.
- storereg then sendreg: mem_en present for both, wb_en only for sendreg, 5 cycles each.
- jzero with flag_zero=1 and target=9 -> pc=9; with flag_zero=0 -> pc=pc+1. jump at pc=15 with target 3 -> pc=3. NOP at pc=15 -> pc wraps to 0.
- halt at pc=5: halted=1, pc stays 5 for 10 cycles; start pulse -> fetch from pc=6.
- Opcode 11111 -> illegal_op pulse, no wb_en; sys_rst_n low during EXECUTE -> state IDLE, pc=0, all strobes 0 immediately.
